// File: rtl/core_pkg.sv
// Shared definitions for the core controller: opcode and state enums,
// instruction word field positions and the LFSR feedback polynomial.
package core_pkg;

    localparam int unsigned DATA_W    = 32;
    localparam int unsigned ITEM_W    = 16;
    localparam int unsigned ADDRJ_W   = 20;

    // Instruction word field positions
    localparam int unsigned OPC_MSB   = 31;
    localparam int unsigned OPC_LSB   = 28;
    localparam int unsigned D2_MSB    = 19;
    localparam int unsigned D2_LSB    = 10;
    localparam int unsigned D1_MSB    = 9;
    localparam int unsigned D1_LSB    = 0;
    localparam int unsigned ADDRJ_MSB = 19;
    localparam int unsigned ADDRJ_LSB = 0;

    // Galois feedback mask for x^32 + x^22 + x^2 + x + 1 (right-shifting form)
    localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

    typedef enum logic [3:0] {
        OP_NOP  = 4'd0,
        OP_GEN  = 4'd1,
        OP_CONF = 4'd2,
        OP_ACC  = 4'd3,
        OP_UPD  = 4'd4,
        OP_END  = 4'd5
    } opcode_t;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_GEN   = 3'd1,
        ST_FETCH = 3'd2,
        ST_EXEC  = 3'd3,
        ST_OUTW  = 3'd4
    } state_t;

    // One Galois LFSR step
    function automatic logic [31:0] lfsr_step(input logic [31:0] v);
        return {1'b0, v[31:1]} ^ (v[0] ? LFSR_TAPS : 32'h0);
    endfunction

endpackage

// File: rtl/core_lfsr.sv
// 32-bit Galois LFSR random source; steps once per i_adv pulse.
// Ports: clk, rst (sync, active-high), i_adv (advance strobe),
//        o_value (current random word).
module core_lfsr
    import core_pkg::*;
#(
    parameter logic [31:0] SEED = 32'hACE1_2024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_adv,
    output logic [31:0] o_value
);

    logic [31:0] r_value;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_value <= SEED;
        end else if (i_adv) begin
            r_value <= lfsr_step(r_value);
        end
    end

    assign o_value = r_value;

endmodule

// File: rtl/core_ctrl.sv
// Core controller: accepts 32-bit instruction words, sequences the core
// through GEN / FETCH / EXEC strobes and streams UPD results out.
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   instr_valid/ready/data    instruction stream (ready only in IDLE)
//   run,gen,get_v,exec,update core control strobes
//   item_a,rand_num,get_d_1/2 core operands, addr_j (last CONF value)
//   core_res_1/2              core results, captured in the UPD EXEC cycle
//   out_valid/ready/data_1/2  result stream
//   rand_in                   external random word (only without the macro)
// Macro CORE_CTRL_LFSR_EN: when defined, rand_num comes from an internal
// LFSR (core_lfsr) and the rand_in port is removed.
module core_ctrl
    import core_pkg::*;
#(
    parameter int unsigned ITEM_AW   = 10,
    parameter logic [31:0] LFSR_SEED = 32'hACE1_2024
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 instr_valid,
    output logic                 instr_ready,
    input  logic [DATA_W-1:0]    instr_data,
    output logic                 run,
    output logic                 gen,
    output logic                 get_v,
    output logic                 exec,
    output logic                 update,
    output logic [ITEM_W-1:0]    item_a,
    output logic [DATA_W-1:0]    rand_num,
    output logic [DATA_W-1:0]    get_d_1,
    output logic [DATA_W-1:0]    get_d_2,
    output logic [ADDRJ_W-1:0]   addr_j,
    input  logic [DATA_W-1:0]    core_res_1,
    input  logic [DATA_W-1:0]    core_res_2,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [DATA_W-1:0]    out_data_1,
    output logic [DATA_W-1:0]    out_data_2
`ifndef CORE_CTRL_LFSR_EN
    ,
    input  logic [DATA_W-1:0]    rand_in
`endif
);

    state_t              r_state;
    state_t              w_state_nxt;
    logic                w_accept;
    opcode_t             w_op;
    logic [DATA_W-1:0]   w_rand_word;

    logic                r_instr_ready;
    logic                r_run;
    logic                r_gen;
    logic                r_get_v;
    logic                r_exec;
    logic                r_update;
    logic                r_is_upd;
    logic [ITEM_W-1:0]   r_item_a;
    logic [DATA_W-1:0]   r_rand_num;
    logic [DATA_W-1:0]   r_get_d_1;
    logic [DATA_W-1:0]   r_get_d_2;
    logic [ADDRJ_W-1:0]  r_addr_j;
    logic                r_out_valid;
    logic [DATA_W-1:0]   r_out_data_1;
    logic [DATA_W-1:0]   r_out_data_2;

    // Reserved instruction bits carry no meaning; seed only feeds the LFSR
    logic                w_unused;
    assign w_unused = ^{instr_data[OPC_LSB-1:D2_MSB+1], LFSR_SEED};

    assign w_accept = instr_valid && (r_state == ST_IDLE);
    assign w_op     = opcode_t'(instr_data[OPC_MSB:OPC_LSB]);

    // Random word source
`ifdef CORE_CTRL_LFSR_EN
    logic w_lfsr_adv;
    assign w_lfsr_adv = w_accept && (w_op == OP_GEN);

    core_lfsr #(
        .SEED    (LFSR_SEED)
    ) u_lfsr (
        .clk     (clk),
        .rst     (rst),
        .i_adv   (w_lfsr_adv),
        .o_value (w_rand_word)
    );
`else
    // External word is captured on the accept edge so it is valid while gen is high
    assign w_rand_word = rand_in;
`endif

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    case (w_op)
                        OP_GEN:         w_state_nxt = ST_GEN;
                        OP_ACC, OP_UPD: w_state_nxt = ST_FETCH;
                        default:        w_state_nxt = ST_IDLE;
                    endcase
                end
            end
            ST_GEN:   w_state_nxt = ST_IDLE;
            ST_FETCH: w_state_nxt = ST_EXEC;
            ST_EXEC:  w_state_nxt = r_is_upd ? ST_OUTW : ST_IDLE;
            ST_OUTW:  w_state_nxt = out_ready ? ST_IDLE : ST_OUTW;
            default:  w_state_nxt = ST_IDLE;
        endcase
    end

    // Registered outputs: strobes are decoded from the next state so they
    // line up exactly with the state they belong to.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_instr_ready <= 1'b1;
            r_run         <= 1'b0;
            r_gen         <= 1'b0;
            r_get_v       <= 1'b0;
            r_exec        <= 1'b0;
            r_update      <= 1'b0;
            r_is_upd      <= 1'b0;
            r_item_a      <= '0;
            r_rand_num    <= '0;
            r_get_d_1     <= '0;
            r_get_d_2     <= '0;
            r_addr_j      <= '0;
            r_out_valid   <= 1'b0;
            r_out_data_1  <= '0;
            r_out_data_2  <= '0;
        end else begin
            r_instr_ready <= (w_state_nxt == ST_IDLE);
            r_gen         <= (w_state_nxt == ST_GEN);
            r_get_v       <= (w_state_nxt == ST_FETCH);
            r_exec        <= (w_state_nxt == ST_EXEC);
            r_update      <= (w_state_nxt == ST_EXEC) && r_is_upd;
            r_out_valid   <= (w_state_nxt == ST_OUTW);

            if (w_accept) begin
                r_is_upd <= (w_op == OP_UPD);
                r_run    <= (w_op != OP_END);
                case (w_op)
                    OP_GEN: begin
                        r_item_a   <= ITEM_W'(instr_data[ITEM_AW-1:0]);
                        r_rand_num <= w_rand_word;
                    end
                    OP_ACC, OP_UPD: begin
                        r_get_d_1 <= DATA_W'(instr_data[D1_MSB:D1_LSB]);
                        r_get_d_2 <= DATA_W'(instr_data[D2_MSB:D2_LSB]);
                    end
                    OP_CONF: begin
                        r_addr_j <= instr_data[ADDRJ_MSB:ADDRJ_LSB];
                    end
                    default: ;
                endcase
            end

            // Results are sampled at the end of the UPD exec cycle and held through OUTW
            if ((r_state == ST_EXEC) && r_is_upd) begin
                r_out_data_1 <= core_res_1;
                r_out_data_2 <= core_res_2;
            end
        end
    end

    assign instr_ready = r_instr_ready;
    assign run         = r_run;
    assign gen         = r_gen;
    assign get_v       = r_get_v;
    assign exec        = r_exec;
    assign update      = r_update;
    assign item_a      = r_item_a;
    assign rand_num    = r_rand_num;
    assign get_d_1     = r_get_d_1;
    assign get_d_2     = r_get_d_2;
    assign addr_j      = r_addr_j;
    assign out_valid   = r_out_valid;
    assign out_data_1  = r_out_data_1;
    assign out_data_2  = r_out_data_2;

endmodule

// File: tb/tb_core_ctrl.sv
// Self-checking bench for core_ctrl: directed table, multi-cycle corner
// sequences (back-pressure, mid-operation reset) and a random instruction
// stream checked against a transaction-level model.
module tb_core_ctrl;

    localparam logic [31:0] SEED = 32'hACE1_2024;
    localparam logic [31:0] TAPS = 32'h8020_0003;

    logic        clk = 1'b0;
    logic        rst;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] instr_data;
    logic        run, gen, get_v, exec, update;
    logic [15:0] item_a;
    logic [31:0] rand_num, get_d_1, get_d_2;
    logic [19:0] addr_j;
    logic [31:0] core_res_1, core_res_2;
    logic        out_valid, out_ready;
    logic [31:0] out_data_1, out_data_2;
    logic [31:0] rand_in;

    int n_tests = 0;
    int n_fail  = 0;

    // Transaction-level model state
    bit          m_run;
    logic [19:0] m_addr_j;
    logic [31:0] m_lfsr;

    always #5 clk = ~clk;

    core_ctrl #(
        .ITEM_AW    (10),
        .LFSR_SEED  (SEED)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr_data  (instr_data),
        .run         (run),
        .gen         (gen),
        .get_v       (get_v),
        .exec        (exec),
        .update      (update),
        .item_a      (item_a),
        .rand_num    (rand_num),
        .get_d_1     (get_d_1),
        .get_d_2     (get_d_2),
        .addr_j      (addr_j),
        .core_res_1  (core_res_1),
        .core_res_2  (core_res_2),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data_1  (out_data_1),
        .out_data_2  (out_data_2)
`ifndef CORE_CTRL_LFSR_EN
        ,
        .rand_in     (rand_in)
`endif
    );

    typedef struct {
        logic [31:0] instr;
        logic [31:0] res1;
        logic [31:0] res2;
        int          hold;
        bit          exp_run;
        logic [19:0] exp_addr_j;
    } vec_t;

    vec_t tbl [12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, want 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Polynomial division step x^32+x^22+x^2+x+1, computed arithmetically
    function automatic logic [31:0] lfsr_next(input logic [31:0] v);
        logic [31:0] s;
        s = v / 2;
        if (v % 2 == 1) s = s ^ TAPS;
        return s;
    endfunction

    task automatic model_reset();
        m_run    = 1'b0;
        m_addr_j = '0;
        m_lfsr   = SEED;
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_strobes"}, {27'b0, run, gen, get_v, exec, update}, 32'h0);
        chk({tag, "_item_a"},  {16'b0, item_a}, 32'h0);
        chk({tag, "_rand"},    rand_num, 32'h0);
        chk({tag, "_get_d"},   get_d_1 | get_d_2, 32'h0);
        chk({tag, "_addr_j"},  {12'b0, addr_j}, 32'h0);
        chk({tag, "_out_v"},   {31'b0, out_valid}, 32'h0);
        chk({tag, "_out_d"},   out_data_1 | out_data_2, 32'h0);
        chk({tag, "_ready"},   {31'b0, instr_ready}, 32'h1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        instr_valid = 1'b0;
        out_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        model_reset();
    endtask

    task automatic wait_ready();
        int w;
        w = 0;
        while (!instr_ready && w < 20) begin
            tick();
            w++;
        end
        if (!instr_ready) chk("ready_timeout", {31'b0, instr_ready}, 32'h1);
    endtask

    // Offer one word and return just after the accepting edge
    task automatic accept(input logic [31:0] ins);
        wait_ready();
        instr_data  = ins;
        instr_valid = 1'b1;
        tick();
        instr_valid = 1'b0;
        instr_data  = $urandom;
    endtask

    // Run one full instruction and check every cycle of its sequence
    task automatic do_instr(input logic [31:0] ins, input logic [31:0] res1,
                            input logic [31:0] res2, input int hold);
        logic [3:0]  op;
        logic [9:0]  d1, d2;
        logic [31:0] rnd, exp_rand;
        op = ins[31:28];
        d1 = ins[9:0];
        d2 = ins[19:10];
        rnd = $urandom;
        rand_in    = rnd;
        core_res_1 = res1;
        core_res_2 = res2;
        out_ready  = 1'b0;
        accept(ins);

        m_run = (op != 4'd5);
        if (op == 4'd2) m_addr_j = ins[19:0];
        chk("run", {31'b0, run}, {31'b0, m_run});
        chk("addr_j", {12'b0, addr_j}, {12'b0, m_addr_j});

        case (op)
            4'd1: begin
`ifdef CORE_CTRL_LFSR_EN
                exp_rand = m_lfsr;
                m_lfsr   = lfsr_next(m_lfsr);
`else
                exp_rand = rnd;
`endif
                chk("gen_strobes", {28'b0, gen, get_v, exec, instr_ready}, 32'h8);
                chk("gen_item_a", {16'b0, item_a}, {22'b0, d1});
                chk("gen_rand", rand_num, exp_rand);
                rand_in = $urandom;
                tick();
                chk("gen_done", {28'b0, gen, get_v, exec, instr_ready}, 32'h1);
            end
            4'd3, 4'd4: begin
                chk("fetch_strobes", {27'b0, gen, get_v, exec, update, instr_ready}, 32'h8);
                chk("fetch_d1", get_d_1, {22'b0, d1});
                chk("fetch_d2", get_d_2, {22'b0, d2});
                tick();
                chk("exec_strobes", {27'b0, gen, get_v, exec, update, instr_ready},
                    (op == 4'd4) ? 32'h6 : 32'h4);
                tick();
                // Results must be those present in the exec cycle only
                core_res_1 = ~res1;
                core_res_2 = ~res2;
                if (op == 4'd3) begin
                    chk("acc_done", {27'b0, gen, get_v, exec, update, instr_ready}, 32'h1);
                end else begin
                    chk("outw_valid", {30'b0, out_valid, instr_ready}, 32'h2);
                    chk("outw_d1", out_data_1, res1);
                    chk("outw_d2", out_data_2, res2);
                    for (int k = 0; k < hold; k++) begin
                        tick();
                        chk("hold_valid", {27'b0, out_valid, instr_ready, exec, update, gen}, 32'h10);
                        chk("hold_d1", out_data_1, res1);
                        chk("hold_d2", out_data_2, res2);
                    end
                    out_ready = 1'b1;
                    tick();
                    out_ready = 1'b0;
                    chk("outw_done", {30'b0, out_valid, instr_ready}, 32'h1);
                end
            end
            default: begin
                chk("quiet_strobes", {27'b0, gen, get_v, exec, update, instr_ready}, 32'h1);
            end
        endcase
    endtask

    // Protocol invariant checker over the whole run
    always @(negedge clk) begin
        if (rst === 1'b0) begin
            n_tests++;
            if ((int'(gen) + int'(get_v) + int'(exec)) > 1 || (update && !exec)) begin
                n_fail++;
                $display("FAIL excl: gen=%0b get_v=%0b exec=%0b update=%0b at %0t",
                         gen, get_v, exec, update, $time);
            end
        end
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        logic [31:0] tmp;
        logic [3:0]  op;

        tbl[0]  = '{32'h1000_0005, 32'h0,         32'h0,         0, 1'b1, 20'h0};
        tbl[1]  = '{32'h1000_03FF, 32'h0,         32'h0,         0, 1'b1, 20'h0};
        tbl[2]  = '{32'h2000_0003, 32'h0,         32'h0,         0, 1'b1, 20'h3};
        tbl[3]  = '{32'h3000_0801, 32'h0,         32'h0,         0, 1'b1, 20'h3};
        tbl[4]  = '{32'h4000_0C05, 32'hDEAD_BEEF, 32'h1234_5678, 4, 1'b1, 20'h3};
        tbl[5]  = '{32'h400F_FFFF, 32'h0,         32'hFFFF_FFFF, 0, 1'b1, 20'h3};
        tbl[6]  = '{32'h5000_0000, 32'h0,         32'h0,         0, 1'b0, 20'h3};
        tbl[7]  = '{32'hF000_0000, 32'h0,         32'h0,         0, 1'b1, 20'h3};
        tbl[8]  = '{32'h5000_0000, 32'h0,         32'h0,         0, 1'b0, 20'h3};
        tbl[9]  = '{32'h200A_BCDE, 32'h0,         32'h0,         0, 1'b1, 20'hABCDE};
        tbl[10] = '{32'h7FFF_FFFF, 32'h0,         32'h0,         0, 1'b1, 20'hABCDE};
        tbl[11] = '{32'h2000_0000, 32'h0,         32'h0,         0, 1'b1, 20'h0};

        rst = 1'b1;
        instr_valid = 1'b0;
        instr_data = '0;
        out_ready = 1'b0;
        core_res_1 = '0;
        core_res_2 = '0;
        rand_in = '0;
        do_reset();
        chk_reset_vals("reset");

        // Directed table
        for (int i = 0; i < 12; i++) begin
            do_instr(tbl[i].instr, tbl[i].res1, tbl[i].res2, tbl[i].hold);
            chk("tbl_run", {31'b0, run}, {31'b0, tbl[i].exp_run});
            chk("tbl_addr_j", {12'b0, addr_j}, {12'b0, tbl[i].exp_addr_j});
        end

        // Reset during FETCH: exec must never follow
        accept(32'h3000_0801);
        chk("mid_fetch_getv", {31'b0, get_v}, 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        chk_reset_vals("rst_fetch");
        tick();
        chk("rst_fetch_noexec1", {29'b0, gen, get_v, exec}, 32'h0);
        tick();
        chk("rst_fetch_noexec2", {29'b0, gen, get_v, exec}, 32'h0);

        // Reset during OUTW: pending result discarded
        core_res_1 = 32'hCAFE_F00D;
        core_res_2 = 32'h0BAD_C0DE;
        accept(32'h4000_0401);
        tick();
        tick();
        chk("mid_outw_valid", {31'b0, out_valid}, 32'h1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        chk_reset_vals("rst_outw");

        // LFSR restarts from seed after reset
        do_instr(32'h1000_0011, 32'h0, 32'h0, 0);

        // Random instruction stream
        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 9))
                0, 1:    op = 4'd1;
                2:       op = 4'd2;
                3, 4:    op = 4'd3;
                5, 6:    op = 4'd4;
                7:       op = 4'd5;
                8:       op = 4'd0;
                default: op = 4'($urandom_range(6, 15));
            endcase
            tmp = $urandom;
            do_instr({op, tmp[27:0]}, $urandom, $urandom, int'($urandom_range(0, 3)));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/core_ctrl.md
CORE_CTRL -- requirements
Module: core_ctrl

Interface
REQ-001 SHALL have parameter ITEM_AW, default 10, meaning item-memory address width (1024 items).
REQ-002 SHALL have parameter LFSR_SEED, default 32'hACE1_2024, meaning LFSR reset value.
REQ-003 SHALL have port clk, input, 1 bit: the single clock.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-005 SHALL have port instr_valid, input, 1 bit: instruction word offered.
REQ-006 SHALL have port instr_ready, output, 1 bit: instruction word accepted on the cycle that has instr_valid&&instr_ready.
REQ-007 SHALL have port instr_data, input, 32 bits: [31:28] opcode; [19:10] d2; [9:0] d1/item_a; [19:0] addr_j for CONF.
REQ-008 SHALL have ports run, gen, get_v, exec, update, outputs, 1 bit each: core controls.
REQ-009 SHALL have ports item_a (16), rand_num (32), get_d_1 (32), get_d_2 (32) and addr_j (20), all outputs: core operands.
REQ-010 SHALL have ports core_res_1 and core_res_2, inputs, 32 bits each: core result_1/result_2.
REQ-011 SHALL have ports out_valid (output, 1), out_ready (input, 1) and out_data_1/out_data_2 (outputs, 32 each): result stream.

Function
REQ-012 SHALL decode opcodes GEN=1, CONF=2, ACC=3, UPD=4, END=5; all other opcodes SHALL be consumed as NOP.
REQ-013 SHALL implement the states IDLE, GEN, FETCH, EXEC, OUTW.
REQ-014 IDLE: instr_ready=1; on accept, SHALL move GEN->GEN, ACC/UPD->FETCH, CONF->IDLE (load addr_j), NOP->IDLE; END SHALL clear run.
REQ-015 SHALL set run to 1 on the first accepted non-END instruction after reset or after END, and SHALL hold it until END is accepted.
REQ-016 GEN: SHALL assert gen for exactly 1 cycle with item_a=d1 (zero-extended) and rand_num=current random word, advance the random source, then return to IDLE.
REQ-017 FETCH: SHALL assert get_v for 1 cycle with get_d_1=d1 and get_d_2=d2 (zero-extended), then go to EXEC.
REQ-018 EXEC: SHALL assert exec for 1 cycle; for UPD it SHALL also assert update, capture core_res_1/2 into out_data_1/2 in that same cycle and go to OUTW; for ACC it SHALL return to IDLE.
REQ-019 OUTW: SHALL assert out_valid and hold out_data stable until out_ready; on the handshake cycle it SHALL go to IDLE; instr_ready SHALL be 0 throughout OUTW.
REQ-020 Latency: ACC SHALL take 3 cycles from accept to IDLE; UPD SHALL present out_valid 3 cycles after accept.
REQ-021 instr_ready SHALL be 1 only in IDLE; back-to-back instructions therefore SHALL be accepted no faster than the state sequence allows.
REQ-022 At most one of gen, get_v and exec SHALL be high in any cycle; update SHALL never be high without exec.
REQ-023 addr_j SHALL hold its last CONF value and SHALL be 0 after reset; CONF while run=0 SHALL still load it.
REQ-024 END received while out_valid is pending is impossible, because no instruction is accepted during OUTW.
REQ-025 Core control outputs SHALL be 0 in every state not listed as asserting them.

Reset
REQ-026 On rst=1: state=IDLE, run=0, all strobes=0, operand outputs=0, addr_j=0, out_valid=0, out_data=0, LFSR=LFSR_SEED.
REQ-027 rst asserted mid-operation (any state, including OUTW) SHALL abort immediately with no further strobes; a pending result SHALL be discarded.

Configuration
REQ-028 With macro CORE_CTRL_LFSR_EN defined, rand_num SHALL come from an internal 32-bit Galois LFSR (taps 32,22,2,1) that advances once per GEN.
REQ-029 Without CORE_CTRL_LFSR_EN, an extra input port rand_in (32 bits) SHALL exist and rand_num SHALL equal rand_in sampled in the GEN cycle; no LFSR SHALL be present.

Structure
REQ-030 A shared package core_pkg SHALL hold the opcode enum, the state enum, the instruction field bit positions and LFSR_TAPS.
REQ-031 One sub-module, core_lfsr, SHALL be instantiated only under CORE_CTRL_LFSR_EN.

Verification
REQ-032 Reset then GEN d1=5 -> run=1; gen pulses 1 cycle with item_a=5 and rand_num=LFSR_SEED; the next GEN yields the advanced LFSR value.
REQ-033 CONF addr_j=3, then ACC d1=1,d2=2 -> get_v with get_d_1=1,get_d_2=2, then exec 1 cycle later; instr_ready low for 2 cycles.
REQ-034 UPD with core_res_1=32'hDEAD_BEEF, core_res_2=32'h1234_5678 and out_ready held 0 for 4 cycles -> out_valid held with stable data and instr_ready=0; release -> IDLE.
REQ-035 rst pulsed in FETCH -> exec never asserts; all outputs are at reset values the next cycle.
REQ-036 END, then opcode 15 -> run=0 after END; the NOP is consumed with no strobes.
REQ-037 A checker SHALL confirm gen/get_v/exec mutual exclusion and update implies exec across a random instruction stream.
